// File: rtl/pagebuf_pkg.sv
// pagebuf_pkg: width helpers and ring-pointer arithmetic
// shared by the page ring buffer and its memory array.
package pagebuf_pkg;

  function automatic int clog2m1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pw_of(input int np);
    return clog2m1(np);
  endfunction

  function automatic int lw_of(input int np);
    return clog2m1(np + 1);
  endfunction

  function automatic int aw_of(input int ps);
    return clog2m1(ps);
  endfunction

  function automatic int ptr_inc(input int p, input int n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/pagebuf_mem.sv
// pagebuf_mem: single-clock simple dual-port array with
// optional input registers; storage itself is never reset.
module pagebuf_mem #(
  parameter string input_regs = "ON",
  parameter int    depth      = 8,
  parameter int    aw         = 3,
  parameter int    dw         = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata,
  output logic          rvalid
);

  localparam bit REG_IN = (input_regs == "ON");

  logic          we_s;
  logic          re_s;
  logic [aw-1:0] waddr_s;
  logic [aw-1:0] raddr_s;
  logic [dw-1:0] wdata_s;

  generate
    if (REG_IN) begin : g_reg
      logic          we_r;
      logic          re_r;
      logic [aw-1:0] waddr_r;
      logic [aw-1:0] raddr_r;
      logic [dw-1:0] wdata_r;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          we_r    <= 1'b0;
          re_r    <= 1'b0;
          waddr_r <= '0;
          raddr_r <= '0;
          wdata_r <= '0;
        end else begin
          we_r    <= we;
          re_r    <= re;
          waddr_r <= waddr;
          raddr_r <= raddr;
          wdata_r <= wdata;
        end
      end

      assign we_s    = we_r;
      assign re_s    = re_r;
      assign waddr_s = waddr_r;
      assign raddr_s = raddr_r;
      assign wdata_s = wdata_r;
    end else begin : g_dir
      assign we_s    = we;
      assign re_s    = re;
      assign waddr_s = waddr;
      assign raddr_s = raddr;
      assign wdata_s = wdata;
    end
  endgenerate

  logic [dw-1:0] mem [depth];

  always_ff @(posedge CLK) begin
    if (we_s) mem[waddr_s] <= wdata_s;
  end

  // same-edge read sees the pre-write word
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re_s;
      if (re_s) rdata <= mem[raddr_s];
    end
  end

endmodule

// File: rtl/pagebuf_ring.sv
// pagebuf_ring: multi-page ring buffer handing whole pages
// from a writer to a reader, with level and error status.
module pagebuf_ring
  import pagebuf_pkg::*;
#(
  parameter string input_regs   = "ON",
  parameter int    num_of_pages = 4,
  parameter int    pagesize     = 1024,
  parameter int    data_width   = 32,
  localparam int   AW = aw_of(pagesize),
  localparam int   PW = pw_of(num_of_pages),
  localparam int   LW = lw_of(num_of_pages),
  localparam int   DEPTH = num_of_pages * pagesize,
  localparam int   MW = clog2m1(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  wren,
  input  logic [AW-1:0]         wraddr,
  input  logic [data_width-1:0] wrdata,
  input  logic                  wrcommit,
  output logic [PW-1:0]         wrpage,
  output logic                  wrfull,
  input  logic                  rden,
  input  logic [AW-1:0]         rdaddr,
  output logic [data_width-1:0] rddata,
  output logic                  rdvalid,
  input  logic                  rdrelease,
  output logic [PW-1:0]         rdpage,
  output logic                  rdempty,
  output logic [LW-1:0]         fill_level,
  output logic                  err_ovf,
  output logic                  err_udf,
  input  logic                  err_clr
);

  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [LW-1:0] fill_q;
  logic          eo_q;
  logic          eu_q;

  assign wrfull = (fill_q == LW'(num_of_pages));
  assign rdempty = (fill_q == '0);

  logic wr_ok, rd_ok, cm_ok, rl_ok;
  logic ovf_ev, udf_ev;

  assign wr_ok = wren & ~wrfull
               & (int'(wraddr) < pagesize);
  assign rd_ok = rden & ~rdempty
               & (int'(rdaddr) < pagesize);
  assign cm_ok = wrcommit & ~wrfull;
  assign rl_ok = rdrelease & ~rdempty;
  assign ovf_ev = (wren | wrcommit) & wrfull;
  assign udf_ev = (rden | rdrelease) & rdempty;

  logic [MW-1:0] wa;
  logic [MW-1:0] ra;

  assign wa = MW'(int'(wp_q) * pagesize + int'(wraddr));
  assign ra = MW'(int'(rp_q) * pagesize + int'(rdaddr));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fill_q <= '0;
    end else begin
      if (cm_ok)
        wp_q <= PW'(ptr_inc(int'(wp_q), num_of_pages));
      if (rl_ok)
        rp_q <= PW'(ptr_inc(int'(rp_q), num_of_pages));
      if (cm_ok && !rl_ok)
        fill_q <= fill_q + LW'(1);
      else if (rl_ok && !cm_ok)
        fill_q <= fill_q - LW'(1);
    end
  end

  // clear wins over a same-cycle setting event
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      eo_q <= 1'b0;
      eu_q <= 1'b0;
    end else if (err_clr) begin
      eo_q <= 1'b0;
      eu_q <= 1'b0;
    end else begin
      if (ovf_ev) eo_q <= 1'b1;
      if (udf_ev) eu_q <= 1'b1;
    end
  end

  assign wrpage     = wp_q;
  assign rdpage     = rp_q;
  assign fill_level = fill_q;
  assign err_ovf    = eo_q;
  assign err_udf    = eu_q;

  pagebuf_mem #(
    .input_regs (input_regs),
    .depth      (DEPTH),
    .aw         (MW),
    .dw         (data_width)
  ) u_mem (
    .CLK    (CLK),
    .nRST   (nRST),
    .we     (wr_ok),
    .waddr  (wa),
    .wdata  (wrdata),
    .re     (rd_ok),
    .raddr  (ra),
    .rdata  (rddata),
    .rvalid (rdvalid)
  );

endmodule

// File: tb/tb_pagebuf_ring.sv
// tb_pagebuf_ring: scoreboard bench driving a registered-input
// and a direct-access ring with identical stimulus.
module tb_pagebuf_ring;

  localparam int NP = 3;
  localparam int PS = 6;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int PW = 2;
  localparam int LW = 2;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          wren = 1'b0;
  logic          wrcommit = 1'b0;
  logic          rden = 1'b0;
  logic          rdrelease = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [AW-1:0] rdaddr = '0;
  logic [DW-1:0] wrdata = '0;

  logic [PW-1:0] wrpage_a, rdpage_a, wrpage_b, rdpage_b;
  logic          wrfull_a, rdempty_a, wrfull_b, rdempty_b;
  logic [DW-1:0] rddata_a, rddata_b;
  logic          rdvalid_a, rdvalid_b;
  logic [LW-1:0] fill_level_a, fill_level_b;
  logic          err_ovf_a, err_udf_a, err_ovf_b, err_udf_b;

  pagebuf_ring #(
    .input_regs("ON"), .num_of_pages(NP),
    .pagesize(PS), .data_width(DW)
  ) u_a (
    .CLK(CLK), .nRST(nRST),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .wrcommit(wrcommit), .wrpage(wrpage_a),
    .wrfull(wrfull_a), .rden(rden), .rdaddr(rdaddr),
    .rddata(rddata_a), .rdvalid(rdvalid_a),
    .rdrelease(rdrelease), .rdpage(rdpage_a),
    .rdempty(rdempty_a), .fill_level(fill_level_a),
    .err_ovf(err_ovf_a), .err_udf(err_udf_a),
    .err_clr(err_clr)
  );

  pagebuf_ring #(
    .input_regs("OFF"), .num_of_pages(NP),
    .pagesize(PS), .data_width(DW)
  ) u_b (
    .CLK(CLK), .nRST(nRST),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .wrcommit(wrcommit), .wrpage(wrpage_b),
    .wrfull(wrfull_b), .rden(rden), .rdaddr(rdaddr),
    .rddata(rddata_b), .rdvalid(rdvalid_b),
    .rdrelease(rdrelease), .rdpage(rdpage_b),
    .rdempty(rdempty_b), .fill_level(fill_level_b),
    .err_ovf(err_ovf_b), .err_udf(err_udf_b),
    .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // reference model
  logic [DW-1:0] mm [NP*PS];
  int wp = 0, rp = 0, fill = 0;
  bit eo = 0, eu = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (rdvalid_a) begin
      if (qa.size() == 0) chk("a.spurious", rdvalid_a, 0);
      else begin
        e = qa.pop_front();
        chk("a.data", rddata_a, e.d);
        chk("a.lat", cyc, e.due);
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      chk("a.missing", rdvalid_a, 1);
      void'(qa.pop_front());
    end
    if (rdvalid_b) begin
      if (qb.size() == 0) chk("b.spurious", rdvalid_b, 0);
      else begin
        e = qb.pop_front();
        chk("b.data", rddata_b, e.d);
        chk("b.lat", cyc, e.due);
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      chk("b.missing", rdvalid_b, 1);
      void'(qb.pop_front());
    end
  end

  task automatic drive(input bit we, input int wa,
                       input logic [DW-1:0] wd,
                       input bit wc, input bit re,
                       input int ra, input bit rr,
                       input bit ec);
    bit full, empty;
    full  = (fill == NP);
    empty = (fill == 0);
    wren = we; wraddr = AW'(wa); wrdata = wd;
    wrcommit = wc; rden = re; rdaddr = AW'(ra);
    rdrelease = rr; err_clr = ec;
    if (re && !empty && ra < PS) begin
      qa.push_back('{mm[rp*PS+ra], cyc + 2});
      qb.push_back('{mm[rp*PS+ra], cyc + 1});
    end
    if (we && !full && wa < PS) mm[wp*PS+wa] = wd;
    if (ec) begin
      eo = 0; eu = 0;
    end else begin
      if ((we || wc) && full) eo = 1;
      if ((re || rr) && empty) eu = 1;
    end
    if (wc && !full) begin
      wp = (wp + 1) % NP; fill++;
    end
    if (rr && !empty) begin
      rp = (rp + 1) % NP; fill--;
    end
    @(posedge CLK); #1;
    wren = 0; wrcommit = 0; rden = 0;
    rdrelease = 0; err_clr = 0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    drive(1, a, d, 0, 0, 0, 0, 0);
  endtask
  task automatic cmt();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic rd(input int a);
    drive(0, 0, 0, 0, 1, a, 0, 0);
  endtask
  task automatic rel();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic st(input string t);
    chk({t, ".wp"}, wrpage_a, wp);
    chk({t, ".rp"}, rdpage_a, rp);
    chk({t, ".fill"}, fill_level_a, fill);
    chk({t, ".full"}, wrfull_a, 32'(fill == NP));
    chk({t, ".empty"}, rdempty_a, 32'(fill == 0));
    chk({t, ".ovf"}, err_ovf_a, eo);
    chk({t, ".udf"}, err_udf_a, eu);
    chk({t, ".b_fill"}, fill_level_b, fill);
    chk({t, ".b_rp"}, rdpage_b, rp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.wp", wrpage_a, 0);
    chk("rst.rp", rdpage_a, 0);
    chk("rst.fill", fill_level_a, 0);
    chk("rst.full", wrfull_a, 0);
    chk("rst.empty", rdempty_a, 1);
    chk("rst.rddata", rddata_a, 0);
    chk("rst.rdvalid", rdvalid_a, 0);
    chk("rst.ovf", err_ovf_a, 0);
    chk("rst.udf", err_udf_a, 0);
    nRST = 1;
    @(posedge CLK); #1;

    for (int i = 0; i < PS; i++) wr(i, 32'h10 + i);
    cmt();
    chk("c1.fill", fill_level_a, 1);
    chk("c1.wp", wrpage_a, 1);
    chk("c1.empty", rdempty_a, 0);
    st("c1");
    rd(5);
    idle(3);

    for (int p = 1; p < NP; p++) begin
      for (int i = 0; i < PS; i++)
        wr(i, 32'h10 + 32'(p) * 32'h10 + i);
      cmt();
    end
    st("full");
    chk("full.flag", wrfull_a, 1);
    drive(1, 0, 32'hDEAD, 1, 0, 0, 0, 0);
    st("ovf");
    chk("ovf.wp", wrpage_a, 0);
    chk("ovf.err", err_ovf_a, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    st("clr");
    drive(1, 0, 32'hBEEF, 0, 0, 0, 0, 1);
    st("clrprio");

    rd(0);
    drive(0, 0, 0, 0, 1, 3, 1, 0);
    st("rel");
    idle(3);

    drive(0, 0, 0, 1, 0, 0, 1, 0);
    st("cr2");
    cmt();
    st("cr_pre");
    drive(0, 0, 0, 1, 0, 0, 1, 0);
    st("crfull");
    rd(2);
    idle(3);

    for (int i = 0; i < NP && fill > 0; i++) rel();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    st("drain");

    for (int k = 0; k < 7; k++) begin
      cmt();
      st("wrap.c");
      chk("wrap.wplim", 32'(wrpage_a < 2'(NP)), 1);
      rel();
      st("wrap.r");
      chk("wrap.rplim", 32'(rdpage_a < 2'(NP)), 1);
    end

    drive(0, 0, 0, 0, 1, 1, 1, 0);
    st("udf");
    idle(3);
    drive(0, 0, 0, 0, 0, 0, 0, 1);

    wr(0, 32'h55);
    cmt();
    rd(6);
    rd(7);
    idle(3);
    st("oob");
    rd(0);
    idle(3);

    rd(1);
    @(negedge CLK); #1;
    nRST = 0;
    qa.delete();
    wp = 0; rp = 0; fill = 0; eo = 0; eu = 0;
    #1;
    chk("rr.valid", rdvalid_a, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rr.rddata", rddata_a, 0);
    chk("rr.b_rddata", rddata_b, 0);
    st("rr");
    nRST = 1;
    idle(3);
    st("post");
    chk("end.qa", qa.size(), 0);
    chk("end.qb", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pagebuf_ring.md
Name: pagebuf_ring

Overview:
Single-clock, multi-page ring buffer built on a simple dual-port memory array. A writer fills the current write page and commits it; a reader reads randomly within the oldest committed page and then releases it. It adds page-ownership tracking, full/empty/fill-level status, sticky error flags and a read-data valid strobe. It sits between line capture and scaler/output stages where whole video lines are handed over as pages.

Parameters:
input_regs, "ON", "ON" registers address/enable/data before the array (+1 cycle read latency); any other value gives direct array access
num_of_pages, 4, number of pages in the ring, >=2, need not be a power of two
pagesize, 1024, words per page, >=2, need not be a power of two
data_width, 32, bits per word

Ports:
CLK  in  1  system clock, all logic on rising edge
nRST  in  1  asynchronous active-low reset
wren  in  1  write strobe into the current write page
wraddr  in  clog2(pagesize)  word address within the write page
wrdata  in  data_width  write data
wrcommit  in  1  current write page complete; hand it to the reader
wrpage  out  PW  index of the current write page (PW = 1 if num_of_pages==1, else clog2(num_of_pages))
wrfull  out  1  all pages committed, no free write page
rden  in  1  read strobe from the current read page
rdaddr  in  clog2(pagesize)  word address within the read page
rddata  out  data_width  read data
rdvalid  out  1  one-cycle strobe: rddata carries the result of an accepted read
rdrelease  in  1  reader done with the current read page
rdpage  out  PW  index of the current read page
rdempty  out  1  no committed page available
fill_level  out  clog2(num_of_pages+1)  number of committed, unreleased pages
err_ovf  out  1  sticky: write or commit attempted while full
err_udf  out  1  sticky: read or release attempted while empty
err_clr  in  1  clears err_ovf and err_udf

Behaviour:
- Reset (async assert, sync release): wrpage=0, rdpage=0, fill_level=0, wrfull=0, rdempty=1, rddata=0, rdvalid=0, err_ovf=0, err_udf=0, pipeline registers cleared. Memory contents are not reset.
- wrfull = (fill_level==num_of_pages); rdempty = (fill_level==0). Both are combinational from the registered count.
- Write accepted when wren=1, wrfull=0 and wraddr<pagesize. Physical address = wrpage*pagesize+wraddr.
  - wren while full: dropped; sets err_ovf.
  - wraddr>=pagesize: dropped silently.
- Read accepted when rden=1, rdempty=0 and rdaddr<pagesize.
  - Latency: rddata/rdvalid 1 cycle after the strobe with input_regs != "ON", 2 cycles with "ON".
  - rddata holds its last value when no read completes; rdvalid=0 on such cycles.
  - rden while empty: no rdvalid; sets err_udf.
- Commit: accepted when wrcommit=1 and wrfull=0 (evaluated on pre-cycle state). wrpage advances to wrpage+1, wrapping num_of_pages-1 -> 0. fill_level increments. Commit while full is ignored and sets err_ovf.
- Release: accepted when rdrelease=1 and rdempty=0. rdpage advances with the same wrap rule. fill_level decrements. Release while empty is ignored and sets err_udf.
- Commit and release in the same cycle, both accepted: both pointers advance and fill_level is unchanged. When full, only the release is accepted. When empty, only the commit is accepted.
- A write in the same cycle as its page's commit still lands in the old page. A read in the same cycle as release still reads the old page; its rdvalid/rddata appear after the pointer moves.
- Read-during-write to the same physical word returns old data. This only occurs through misuse, since wrpage==rdpage implies full or empty.
- Errors: err_clr has priority over a setting event in the same cycle.
- Reset mid-operation discards all pages and any in-flight read; rdvalid is forced to 0 immediately.

Decomposition:
- Package pagebuf_pkg: PW and address/level width functions (clog2 with a minimum of 1), and a pointer-increment-with-wrap function.
- Sub-module pagebuf_mem: single-clock simple dual-port array with optional input registers and no reset on storage. The ring control, counters and flags stay in pagebuf_ring.

Test Plan:
- Reset, num_of_pages=4, pagesize=8: write words 0..7 = 0x10..0x17 to page 0, commit -> fill_level=1, wrpage=1, rdempty=0. Read addr 5 -> rddata=0x15 with rdvalid exactly 2 cycles later (input_regs="ON") or 1 cycle later (input_regs="OFF").
- Four commits with no release -> wrfull=1, fill_level=4. A fifth wren+wrcommit -> data not written, wrpage unchanged, err_ovf=1. err_clr -> err_ovf=0.
- num_of_pages=3: 7 commit/release pairs -> wrpage and rdpage follow the sequence 0,1,2,0,1,2,0,1 and never reach 3.
- Simultaneous commit and release at fill_level=2 -> fill_level stays 2 and both pointers advance. At full, same stimulus -> fill_level=3, only rdpage advances.
- rden and rdrelease while empty -> no rdvalid, err_udf=1, rdpage=0. rdaddr=pagesize with a valid page -> no rdvalid, no error.
- nRST asserted one cycle after an accepted rden -> rdvalid stays 0, rddata=0, all pointers 0, rdempty=1.
